// File: rtl/ritc_lane_align_ctrl.sv
// Lane alignment sequencer: walks every deserialized lane, bitslipping each one until
// its training word has been seen MATCH_COUNT times in a row, or failing it after DESER-1 slips.

module ritc_lane_match #(
  parameter int               DESER         = 4,
  parameter logic [DESER-1:0] TRAIN_PATTERN = '0,
  parameter logic             POLARITY      = 1'b0
) (
  input  logic [DESER-1:0] i_dat,
  output logic             o_match
);
  assign o_match = ((i_dat ^ {DESER{POLARITY}}) == TRAIN_PATTERN);
endmodule

module ritc_lane_align_ctrl #(
  parameter int                NLANES        = 72,
  parameter int                DESER         = 4,
  parameter logic [DESER-1:0]  TRAIN_PATTERN = 4'b1010,
  parameter logic [NLANES-1:0] BIT_POLARITY  = '0,
  parameter int                MATCH_COUNT   = 16,
  parameter int                SETTLE        = 8,
  localparam int               LW            = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                    SYSCLK,
  input  logic                    RST,
  input  logic [NLANES*DESER-1:0] dat_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic [NLANES-1:0]       bitslip_o,
  output logic [NLANES-1:0]       lock_o,
  output logic [NLANES-1:0]       lane_fail_o,
  output logic                    fail_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LW-1:0]           lane_o
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int PW = (DESER > 1) ? $clog2(DESER) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [PW-1:0] SLIP_LAST   = PW'(DESER - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [LW-1:0] LANE_LAST   = LW'(NLANES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_SLIP, S_SETTLE, S_NEXT, S_DONE
  } state_t;

  state_t            r_state, w_nstate;
  logic [LW-1:0]     r_lane;
  logic [MW-1:0]     r_match;
  logic [PW-1:0]     r_slip;
  logic [SW-1:0]     r_settle;
  logic [NLANES-1:0] r_lock, r_fail;
  logic [NLANES-1:0] w_match;
  logic              w_cur_match;
  logic              w_abort;

  genvar g;
  generate
    for (g = 0; g < NLANES; g++) begin : g_lane
      ritc_lane_match #(
        .DESER         (DESER),
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .POLARITY      (BIT_POLARITY[g])
      ) u_match (
        .i_dat   (dat_i[g*DESER +: DESER]),
        .o_match (w_match[g])
      );
    end
  endgenerate

  assign w_cur_match = w_match[r_lane];
  assign w_abort     = abort_i && (r_state != S_IDLE);

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate  = r_state;
    bitslip_o = '0;
    busy_o    = (r_state != S_IDLE);
    done_o    = 1'b0;
    case (r_state)
      S_IDLE:    if (start_i && !abort_i) w_nstate = S_COMPARE;
      S_COMPARE: begin
        if (w_cur_match) begin
          if (r_match == MATCH_LAST) w_nstate = S_NEXT;
        end else if (r_slip == SLIP_LAST) begin
          w_nstate = S_NEXT;
        end else begin
          w_nstate = S_SLIP;
        end
      end
      S_SLIP: begin
        bitslip_o[r_lane] = 1'b1;
        w_nstate          = S_SETTLE;
      end
      S_SETTLE:  if (r_settle == SETTLE_LAST) w_nstate = S_COMPARE;
      S_NEXT:    w_nstate = (r_lane == LANE_LAST) ? S_DONE : S_COMPARE;
      S_DONE: begin
        done_o   = 1'b1;
        w_nstate = S_IDLE;
      end
      default:   w_nstate = S_IDLE;
    endcase
    if (w_abort) w_nstate = S_IDLE;
  end

  // Abort freezes every counter and flag; only the state returns to IDLE.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      r_lane   <= '0;
      r_match  <= '0;
      r_slip   <= '0;
      r_settle <= '0;
      r_lock   <= '0;
      r_fail   <= '0;
    end else if (!w_abort) begin
      case (r_state)
        S_IDLE: if (start_i && !abort_i) begin
          r_lane  <= '0;
          r_match <= '0;
          r_slip  <= '0;
          r_lock  <= '0;
          r_fail  <= '0;
        end
        S_COMPARE: begin
          if (w_cur_match) begin
            r_match <= r_match + MW'(1);
            if (r_match == MATCH_LAST) r_lock[r_lane] <= 1'b1;
          end else begin
            r_match <= '0;
            if (r_slip == SLIP_LAST) r_fail[r_lane] <= 1'b1;
          end
        end
        S_SLIP: begin
          r_slip   <= r_slip + PW'(1);
          r_settle <= '0;
        end
        S_SETTLE: r_settle <= r_settle + SW'(1);
        S_NEXT: if (r_lane != LANE_LAST) begin
          r_lane  <= r_lane + LW'(1);
          r_slip  <= '0;
          r_match <= '0;
        end
        default: ;
      endcase
    end
  end

  assign lock_o      = r_lock;
  assign lane_fail_o = r_fail;
  assign fail_o      = |r_fail;
  assign lane_o      = r_lane;

endmodule

// File: tb/tb_ritc_lane_align_ctrl.sv
// Bench for ritc_lane_align_ctrl: per-lane slip requirements become a cycle schedule
// of expected outputs, and the data stream is generated open-loop from that schedule.

module tb_ritc_lane_align_ctrl;
  localparam int NL = 4, DS = 4, MC = 4, ST = 2, NC = 128;

  logic SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  logic        RST, start_i, abort_i;
  logic [15:0] dat_n;
  logic [15:0] dat_p;
  assign dat_p = dat_n ^ 16'h000F;

  logic [3:0] n_bs, n_lock, n_fail, p_bs, p_lock, p_fail;
  logic       n_failo, n_busy, n_done, p_failo, p_busy, p_done;
  logic [1:0] n_lane, p_lane;

  ritc_lane_align_ctrl #(.NLANES(NL), .DESER(DS), .TRAIN_PATTERN(4'b1010),
    .BIT_POLARITY(4'b0000), .MATCH_COUNT(MC), .SETTLE(ST)) u_dut (
    .SYSCLK(SYSCLK), .RST(RST), .dat_i(dat_n), .start_i(start_i), .abort_i(abort_i),
    .bitslip_o(n_bs), .lock_o(n_lock), .lane_fail_o(n_fail), .fail_o(n_failo),
    .busy_o(n_busy), .done_o(n_done), .lane_o(n_lane));

  // Same stream with lane 0 inverted, so it behaves identically through its polarity flip.
  ritc_lane_align_ctrl #(.NLANES(NL), .DESER(DS), .TRAIN_PATTERN(4'b1010),
    .BIT_POLARITY(4'b0001), .MATCH_COUNT(MC), .SETTLE(ST)) u_dut_pol (
    .SYSCLK(SYSCLK), .RST(RST), .dat_i(dat_p), .start_i(start_i), .abort_i(abort_i),
    .bitslip_o(p_bs), .lock_o(p_lock), .lane_fail_o(p_fail), .fail_o(p_failo),
    .busy_o(p_busy), .done_o(p_done), .lane_o(p_lane));

  logic       sel;
  logic [3:0] o_bs, o_lock, o_fail;
  logic       o_failo, o_busy, o_done;
  logic [1:0] o_lane;
  assign o_bs    = sel ? p_bs    : n_bs;
  assign o_lock  = sel ? p_lock  : n_lock;
  assign o_fail  = sel ? p_fail  : n_fail;
  assign o_failo = sel ? p_failo : n_failo;
  assign o_busy  = sel ? p_busy  : n_busy;
  assign o_done  = sel ? p_done  : n_done;
  assign o_lane  = sel ? p_lane  : n_lane;

  int n_cmp = 0, n_bad = 0;
  int ga[NL];                 // slips a lane needs before it shows the pattern; >=DS never
  logic [3:0] prev_lock = '0, prev_fail = '0;
  int prev_lane = 0;
  int obs_done, obs_pulses;
  logic [3:0] obs_lock, obs_fail;

  task automatic run_align(input int abort_at, input int rst_at, input bit noise_start);
    logic [3:0] e_bs[NC], e_lock[NC], e_fail[NC];
    bit   e_busy[NC], e_done[NC], e_settle[NC];
    int   e_lane[NC];
    int   c0[NL], ce[NL], gs[NL];
    bit   lk[NL];
    int   c, done, last, ns, len, m;
    logic [3:0] good, w;
    for (int t = 0; t < NC; t++) begin
      e_bs[t] = '0; e_busy[t] = 0; e_done[t] = 0; e_settle[t] = 0;
      e_lane[t] = prev_lane; e_lock[t] = prev_lock; e_fail[t] = prev_fail;
    end
    c = 1;
    for (int k = 0; k < NL; k++) begin
      lk[k] = (ga[k] < DS);
      ns    = lk[k] ? ga[k] : DS - 1;
      len   = ns * (2 + ST) + (lk[k] ? MC + 1 : 2);
      c0[k] = c; ce[k] = c + len - 1; gs[k] = c + ns * (2 + ST);
      for (int j = 0; j < ns; j++) begin
        m = c + j * (2 + ST);
        e_bs[m + 1][k] = 1'b1;
        for (int s = 0; s < ST; s++) e_settle[m + 2 + s] = 1;
      end
      c += len;
    end
    done = c;
    last = done + 2;
    for (int t = 1; t <= last; t++) begin
      e_busy[t] = (t <= done);
      e_lane[t] = NL - 1;
      e_lock[t] = '0; e_fail[t] = '0;
      for (int k = 0; k < NL; k++) begin
        if (t >= c0[k] && t <= ce[k]) e_lane[t] = k;
        if (t >= ce[k]) begin
          if (lk[k]) e_lock[t][k] = 1'b1;
          else       e_fail[t][k] = 1'b1;
        end
      end
    end
    e_done[done] = 1;
    if (abort_at == -2) abort_at = $urandom_range(1, done - 1);
    if (abort_at >= 0) begin
      for (int t = abort_at + 1; t < NC; t++) begin
        e_busy[t] = 0; e_done[t] = 0; e_bs[t] = '0; e_lane[t] = e_lane[abort_at];
        e_lock[t] = e_lock[abort_at]; e_fail[t] = e_fail[abort_at];
      end
      last = abort_at + 3;
    end
    if (rst_at >= 0) begin
      for (int t = rst_at; t < NC; t++) begin
        e_busy[t] = 0; e_done[t] = 0; e_bs[t] = '0; e_lane[t] = 0;
        e_lock[t] = '0; e_fail[t] = '0;
      end
      last = rst_at + 3;
    end
    obs_done = -1; obs_pulses = 0;
    for (int t = 0; t <= last; t++) begin
      @(negedge SYSCLK);
      start_i = (t == 0) || (noise_start && e_busy[t] && $urandom_range(0, 3) == 0);
      abort_i = (t == abort_at);
      RST     = (t == rst_at);
      for (int k = 0; k < NL; k++) begin
        good = 4'b1010;
        w    = 4'($urandom_range(0, 15));
        if (t >= c0[k] && t <= ce[k] && !e_settle[t]) begin
          if (lk[k] && t >= gs[k]) w = good;
          else while (w == good) w = 4'($urandom_range(0, 15));
        end
        dat_n[k*4 +: 4] = w;
      end
      #1;
      if (o_busy !== e_busy[t]) begin n_bad++; $display("FAIL busy t=%0d got %b exp %b", t, o_busy, e_busy[t]); end
      if (o_done !== e_done[t]) begin n_bad++; $display("FAIL done t=%0d got %b exp %b", t, o_done, e_done[t]); end
      if (o_bs !== e_bs[t]) begin n_bad++; $display("FAIL bitslip t=%0d got %b exp %b", t, o_bs, e_bs[t]); end
      if (o_lane !== 2'(e_lane[t])) begin n_bad++; $display("FAIL lane t=%0d got %0d exp %0d", t, o_lane, e_lane[t]); end
      if (o_lock !== e_lock[t]) begin n_bad++; $display("FAIL lock t=%0d got %b exp %b", t, o_lock, e_lock[t]); end
      if (o_fail !== e_fail[t]) begin n_bad++; $display("FAIL lane_fail t=%0d got %b exp %b", t, o_fail, e_fail[t]); end
      if (o_failo !== (|e_fail[t])) begin n_bad++; $display("FAIL fail_o t=%0d got %b exp %b", t, o_failo, |e_fail[t]); end
      n_cmp += 7;
      if (o_done === 1'b1 && obs_done < 0) obs_done = t;
      if (o_bs !== 4'b0000) obs_pulses++;
    end
    start_i = 0; abort_i = 0; RST = 0;
    obs_lock = o_lock; obs_fail = o_fail;
    prev_lock = e_lock[last]; prev_fail = e_fail[last]; prev_lane = e_lane[last];
  endtask

  task automatic test_reset();
    RST = 1; start_i = 0; abort_i = 0; dat_n = '0; sel = 0;
    repeat (2) @(negedge SYSCLK);
    #1;
    n_cmp++;
    if ({n_bs, n_lock, n_fail, n_failo, n_busy, n_done, n_lane} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %b exp 0", {n_bs, n_lock, n_fail, n_failo, n_busy, n_done, n_lane});
    end
    @(negedge SYSCLK); RST = 0;
  endtask

  task automatic test_all_match();
    sel = 0; ga = '{0, 0, 0, 0};
    run_align(-1, -1, 0);
    n_cmp += 3;
    if (obs_done !== 21) begin n_bad++; $display("FAIL all_match_done got %0d exp 21", obs_done); end
    if (obs_pulses !== 0) begin n_bad++; $display("FAIL all_match_slips got %0d exp 0", obs_pulses); end
    if (obs_lock !== 4'b1111) begin n_bad++; $display("FAIL all_match_lock got %b exp 1111", obs_lock); end
  endtask

  task automatic test_one_slip();
    sel = 0; ga = '{0, 0, 1, 0};
    run_align(-1, -1, 1);
    n_cmp += 3;
    if (obs_done !== 25) begin n_bad++; $display("FAIL one_slip_done got %0d exp 25", obs_done); end
    if (obs_pulses !== 1) begin n_bad++; $display("FAIL one_slip_pulses got %0d exp 1", obs_pulses); end
    if (obs_lock !== 4'b1111) begin n_bad++; $display("FAIL one_slip_lock got %b exp 1111", obs_lock); end
  endtask

  task automatic test_lane_fail();
    sel = 0; ga = '{0, 9, 0, 0};
    run_align(-1, -1, 0);
    n_cmp += 4;
    if (obs_done !== 30) begin n_bad++; $display("FAIL lane_fail_done got %0d exp 30", obs_done); end
    if (obs_pulses !== 3) begin n_bad++; $display("FAIL lane_fail_pulses got %0d exp 3", obs_pulses); end
    if (obs_lock !== 4'b1101) begin n_bad++; $display("FAIL lane_fail_lock got %b exp 1101", obs_lock); end
    if (obs_fail !== 4'b0010) begin n_bad++; $display("FAIL lane_fail_flags got %b exp 0010", obs_fail); end
  endtask

  task automatic test_polarity();
    sel = 1; ga = '{0, 0, 0, 0};
    run_align(-1, -1, 0);
    n_cmp += 2;
    if (obs_pulses !== 0) begin n_bad++; $display("FAIL polarity_slips got %0d exp 0", obs_pulses); end
    if (obs_lock !== 4'b1111) begin n_bad++; $display("FAIL polarity_lock got %b exp 1111", obs_lock); end
    sel = 0;
  endtask

  task automatic test_abort();
    sel = 0; ga = '{0, 0, 0, 0};
    run_align(11, -1, 0);
    n_cmp += 2;
    if (obs_lock !== 4'b0011) begin n_bad++; $display("FAIL abort_lock got %b exp 0011", obs_lock); end
    if (obs_done !== -1) begin n_bad++; $display("FAIL abort_done got %0d exp -1", obs_done); end
  endtask

  task automatic test_abort_start_idle();
    @(negedge SYSCLK); start_i = 1; abort_i = 1;
    @(negedge SYSCLK); start_i = 0; abort_i = 0;
    #1;
    n_cmp += 2;
    if (n_busy !== 1'b0) begin n_bad++; $display("FAIL abort_start_busy got %b exp 0", n_busy); end
    if (n_lock !== prev_lock) begin n_bad++; $display("FAIL abort_start_lock got %b exp %b", n_lock, prev_lock); end
  endtask

  task automatic test_rst_mid();
    sel = 0; ga = '{2, 0, 0, 0};
    run_align(-1, 3, 0);
    n_cmp++;
    if (obs_pulses !== 1) begin n_bad++; $display("FAIL rst_mid_pulses got %0d exp 1", obs_pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom_range(0, 1));
      for (int k = 0; k < NL; k++) begin
        ga[k] = $urandom_range(0, 6);
        if (ga[k] > 4) ga[k] = 0;
      end
      run_align(($urandom_range(0, 3) == 0) ? -2 : -1, -1, 1);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_one_slip();
    test_lane_fail();
    test_polarity();
    test_abort();
    test_abort_start_idle();
    test_all_match();
    test_rst_mid();
    test_all_match();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
